// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared receiver frame-check types, parity constants and sticky-flag bit positions
package uart_rx_pkg;
    typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP1, STOP2} state_t;
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;
    localparam int ERR_PAR  = 0;
    localparam int ERR_STOP = 1;
    localparam int ERR_BRK  = 2;
endpackage

// File: rtl/uart_parity_calc.sv
// uart_parity_calc: expected parity bit for a received data word (even or odd)
module uart_parity_calc
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);
    assign par_bit = (^data) ^ (par_typ == PAR_ODD);
endmodule

// File: rtl/uart_frame_check.sv
// uart_frame_check: assembles sampled UART bits into a frame and flags parity, stop and break errors
module uart_frame_check
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int STOP_BITS_MAX = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  frame_start,
    input  logic                  bit_valid,
    input  logic                  Sampled_Bit,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  stop_sel,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  Parity_error,
    output logic                  Stop_error,
    output logic                  Break_det,
    output logic [2:0]            err_sticky,
    output logic                  busy
);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    state_t                state, state_nx;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] sh;
    logic                  par_en_l, par_typ_l, stop_sel_l;
    logic                  par_f, stop_f, zero_f;
    logic                  exp_par, two_stop, last_data, done, brk;
    logic [2:0]            flags;

    uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_par (
        .data   (sh),
        .par_typ(par_typ_l),
        .par_bit(exp_par)
    );

    assign two_stop  = stop_sel_l && (STOP_BITS_MAX == 2);
    assign last_data = cnt == CW'(DATA_WIDTH - 1);
    assign done      = bit_valid && !frame_start && (state == STOP2 || (state == STOP1 && !two_stop));
    assign busy      = state != IDLE;
    // zero_f already covers STOP1 once in STOP2; the second stop bit never counts toward break
    assign brk       = zero_f && (state == STOP2 || !Sampled_Bit);

    always_comb begin
        flags           = 3'b000;
        flags[ERR_BRK]  = brk;
        flags[ERR_STOP] = stop_f || !Sampled_Bit || brk;
        flags[ERR_PAR]  = par_f && !brk;
    end

    always_comb begin
        state_nx = state;
        if (frame_start)
            state_nx = DATA;
        else if (bit_valid)
            case (state)
                DATA:    state_nx = last_data ? (par_en_l ? PARITY : STOP1) : DATA;
                PARITY:  state_nx = STOP1;
                STOP1:   state_nx = two_stop ? STOP2 : IDLE;
                default: state_nx = IDLE;
            endcase
    end

    always_ff @(posedge CLK or negedge RST)
        if (!RST)
            state <= IDLE;
        else
            state <= state_nx;

    always_ff @(posedge CLK or negedge RST)
        if (!RST) begin
            cnt          <= '0;
            sh           <= '0;
            par_en_l     <= 1'b0;
            par_typ_l    <= 1'b0;
            stop_sel_l   <= 1'b0;
            par_f        <= 1'b0;
            stop_f       <= 1'b0;
            zero_f       <= 1'b0;
            data_out     <= '0;
            data_valid   <= 1'b0;
            Parity_error <= 1'b0;
            Stop_error   <= 1'b0;
            Break_det    <= 1'b0;
            err_sticky   <= 3'b000;
        end else begin
            data_valid <= done && flags == 3'b000;
            err_sticky <= (err_sticky & {3{!err_clr}}) | (flags & {3{done}});
            if (frame_start) begin
                cnt        <= '0;
                sh         <= '0;
                par_en_l   <= PAR_EN;
                par_typ_l  <= PAR_TYP;
                stop_sel_l <= stop_sel;
                par_f      <= 1'b0;
                stop_f     <= 1'b0;
                zero_f     <= 1'b1;
            end else if (bit_valid) begin
                if (state == DATA) begin
                    sh  <= {Sampled_Bit, sh[DATA_WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                end
                if (state == PARITY)
                    par_f <= Sampled_Bit ^ exp_par;
                if (state == STOP1)
                    stop_f <= !Sampled_Bit;
                if (state inside {DATA, PARITY, STOP1})
                    zero_f <= zero_f && !Sampled_Bit;
                if (done) begin
                    data_out     <= sh;
                    Parity_error <= flags[ERR_PAR];
                    Stop_error   <= flags[ERR_STOP];
                    Break_det    <= flags[ERR_BRK];
                end
            end
        end
endmodule
